// File: rtl/dct2d_pkg.sv
// Shared types and constants for the 8x8 streaming DCT: coefficient table
// (cosines scaled by 128), default widths and the engine state encoding.
package dct2d_pkg;

   localparam int DEF_COEF_W = 8;
   localparam int DEF_FRAC   = 7;

   typedef enum logic [1:0] {LOAD, S1, S2, OUT} state_t;

   typedef logic signed [DEF_COEF_W-1:0] coef_t;

   localparam coef_t C [8][8] = '{
      '{ 8'sd45,  8'sd45,  8'sd45,  8'sd45,  8'sd45,  8'sd45,  8'sd45,  8'sd45},
      '{ 8'sd63,  8'sd53,  8'sd36,  8'sd12, -8'sd12, -8'sd36, -8'sd53, -8'sd63},
      '{ 8'sd59,  8'sd24, -8'sd24, -8'sd59, -8'sd59, -8'sd24,  8'sd24,  8'sd59},
      '{ 8'sd53, -8'sd12, -8'sd63, -8'sd36,  8'sd36,  8'sd63,  8'sd12, -8'sd53},
      '{ 8'sd45, -8'sd45, -8'sd45,  8'sd45,  8'sd45, -8'sd45, -8'sd45,  8'sd45},
      '{ 8'sd36, -8'sd63,  8'sd12,  8'sd53, -8'sd53, -8'sd12,  8'sd63, -8'sd36},
      '{ 8'sd24, -8'sd59,  8'sd59, -8'sd24, -8'sd24,  8'sd59, -8'sd59,  8'sd24},
      '{ 8'sd12, -8'sd36,  8'sd53, -8'sd63,  8'sd63, -8'sd53,  8'sd36, -8'sd12}
   };

   // Inverse passes use the transposed table, i.e. C[j][k] instead of C[k][j].
   function automatic coef_t coef(input logic [2:0] k, input logic [2:0] j,
                                  input logic transpose);
      return transpose ? C[j][k] : C[k][j];
   endfunction

endpackage

// File: rtl/dct2d_stream_if.sv
// Row-stream handshake bundle for dct2d_stream: one packed 8-sample row per
// beat on the input side, one packed 8-result row per beat on the output side.
interface dct2d_stream_if #(
   parameter int N = 8
) ();

   logic              in_valid;
   logic              in_ready;
   logic [8*N-1:0]    in_row;
   logic              in_mode;
   logic              out_valid;
   logic              out_ready;
   logic [8*(N+8)-1:0] out_row;
   logic              out_last;

   modport master (
      output in_valid, in_row, in_mode, out_ready,
      input  in_ready, out_valid, out_row, out_last
   );

   modport slave (
      input  in_valid, in_row, in_mode, out_ready,
      output in_ready, out_valid, out_row, out_last
   );

endinterface

// File: rtl/dct2d_dot8.sv
// Combinational 8-tap signed dot product with a full-precision adder tree;
// shared by both 1-D passes of dct2d_stream.
module dct2d_dot8 #(
   parameter  int A_W = 12,
   parameter  int B_W = 8,
   localparam int S_W = A_W + B_W + 3
) (
   input  logic signed [A_W-1:0] a [8],
   input  logic signed [B_W-1:0] b [8],
   output logic signed [S_W-1:0] sum
);

   localparam int P_W = A_W + B_W;

   logic signed [P_W-1:0] prod [8];
   logic signed [P_W:0]   lvl1 [4];
   logic signed [P_W+1:0] lvl2 [2];

   for (genvar gi = 0; gi < 8; gi++) begin : g_mul
      assign prod[gi] = P_W'(a[gi]) * P_W'(b[gi]);
   end

   for (genvar gi = 0; gi < 4; gi++) begin : g_lvl1
      assign lvl1[gi] = (P_W+1)'(prod[2*gi]) + (P_W+1)'(prod[2*gi+1]);
   end

   for (genvar gi = 0; gi < 2; gi++) begin : g_lvl2
      assign lvl2[gi] = (P_W+2)'(lvl1[2*gi]) + (P_W+2)'(lvl1[2*gi+1]);
   end

   assign sum = S_W'(lvl2[0]) + S_W'(lvl2[1]);

endmodule

// File: rtl/dct2d_stream.sv
// Streaming 8x8 2-D DCT / IDCT via row-column decomposition on one shared
// dot8 unit. Define DCT2D_ROUND_EN for round-half-up after each pass.
module dct2d_stream
   import dct2d_pkg::*;
#(
   parameter int N      = 8,
   parameter int COEF_W = DEF_COEF_W,
   parameter int FRAC   = DEF_FRAC
) (
   input  logic           clk,
   input  logic           reset,
   dct2d_stream_if.slave  s,
   output logic           busy,
   output logic           done
);

   localparam int ZW = N + 4;
   localparam int YW = N + 8;
   localparam int SW = ZW + COEF_W + 3;

   state_t state_reg, state_next;
   logic [2:0] rcnt_reg;
   logic [5:0] ecnt_reg;
   logic       mode_reg;
   logic       out_valid_reg, out_last_reg, done_reg;
   logic [8*YW-1:0] out_row_reg;

   logic signed [N-1:0]  xbuf [64];
   logic signed [ZW-1:0] zbuf [64];
   logic signed [YW-1:0] ybuf [64];

   logic in_ready_c, busy_c, in_fire;
   logic [2:0] ei, ek, yr_idx;
   logic [8*YW-1:0] yrow_sel;
   logic signed [ZW-1:0]     op_a [8];
   logic signed [COEF_W-1:0] op_b [8];
   logic signed [SW-1:0]     acc, acc_adj;
   logic signed [YW-1:0]     y_val;

   assign ei      = ecnt_reg[5:3];
   assign ek      = ecnt_reg[2:0];
   assign in_fire = s.in_valid & in_ready_c;

   // Pass 1 reads row i of X, pass 2 reads column i of Z; coefficients match.
   for (genvar gi = 0; gi < 8; gi++) begin : g_op
      assign op_a[gi] = (state_reg == S2) ? zbuf[{3'(gi), ei}]
                                          : ZW'(xbuf[{ei, 3'(gi)}]);
      assign op_b[gi] = COEF_W'(coef(ek, 3'(gi), mode_reg));
   end

   dct2d_dot8 #(.A_W(ZW), .B_W(COEF_W)) u_dot (
      .a   (op_a),
      .b   (op_b),
      .sum (acc)
   );

`ifdef DCT2D_ROUND_EN
   localparam logic signed [SW-1:0] HALF = SW'(1) <<< (FRAC - 1);
   assign acc_adj = acc + HALF;
`else
   assign acc_adj = acc;
`endif

   assign y_val = YW'(acc_adj >>> FRAC);

   // Once a row is on the bus, the next one to preload is rcnt+1.
   assign yr_idx = out_valid_reg ? rcnt_reg + 3'd1 : rcnt_reg;
   for (genvar gi = 0; gi < 8; gi++) begin : g_yrow
      assign yrow_sel[gi*YW +: YW] = ybuf[{yr_idx, 3'(gi)}];
   end

   always_ff @(posedge clk) begin
      if (in_fire) begin
         for (int j = 0; j < 8; j++) begin
            xbuf[{rcnt_reg, 3'(j)}] <= s.in_row[j*N +: N];
         end
      end
      if (state_reg == S1) zbuf[ecnt_reg] <= y_val[ZW-1:0];
      if (state_reg == S2) ybuf[{ek, ei}] <= y_val;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_reg <= LOAD;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         LOAD:    if (in_fire && rcnt_reg == 3'd7) state_next = S1;
         S1:      if (ecnt_reg == 6'd63) state_next = S2;
         S2:      if (ecnt_reg == 6'd63) state_next = OUT;
         OUT:     if (out_valid_reg && s.out_ready && rcnt_reg == 3'd7) state_next = LOAD;
         default: state_next = LOAD;
      endcase
   end

   always_comb begin
      in_ready_c = 1'b0;
      busy_c     = 1'b1;
      if (state_reg == LOAD) begin
         in_ready_c = 1'b1;
         busy_c     = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rcnt_reg      <= '0;
         ecnt_reg      <= '0;
         mode_reg      <= 1'b0;
         out_valid_reg <= 1'b0;
         out_row_reg   <= '0;
         out_last_reg  <= 1'b0;
         done_reg      <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            LOAD: begin
               if (in_fire) begin
                  if (rcnt_reg == 3'd0) mode_reg <= s.in_mode;
                  rcnt_reg <= rcnt_reg + 3'd1;
                  ecnt_reg <= '0;
               end
            end
            S1, S2: ecnt_reg <= ecnt_reg + 6'd1;
            OUT: begin
               if (!out_valid_reg) begin
                  out_valid_reg <= 1'b1;
                  out_row_reg   <= yrow_sel;
                  out_last_reg  <= (yr_idx == 3'd7);
               end else if (s.out_ready) begin
                  if (rcnt_reg == 3'd7) begin
                     out_valid_reg <= 1'b0;
                     out_row_reg   <= '0;
                     out_last_reg  <= 1'b0;
                     done_reg      <= 1'b1;
                     rcnt_reg      <= '0;
                  end else begin
                     rcnt_reg      <= rcnt_reg + 3'd1;
                     out_row_reg   <= yrow_sel;
                     out_last_reg  <= (yr_idx == 3'd7);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign s.in_ready  = in_ready_c;
   assign s.out_valid = out_valid_reg;
   assign s.out_row   = out_row_reg;
   assign s.out_last  = out_last_reg;
   assign busy        = busy_c;
   assign done        = done_reg;

endmodule

// File: tb/tb_dct2d_stream.sv
// Directed bench for dct2d_stream: hand-derived DCT/IDCT blocks, latency,
// backpressure, mid-block reset, mode sampling and a reference-model block.
module tb_dct2d_stream;

   logic clk = 1'b0;
   logic reset;
   logic busy, done;

   dct2d_stream_if #(.N(8)) bus ();

   dct2d_stream #(.N(8)) dut (
      .clk   (clk),
      .reset (reset),
      .s     (bus.slave),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

`ifdef DCT2D_ROUND_EN
   localparam int RND     = 64;
   localparam int E_FWD10 = 79;
   localparam int E_NEG   = -1012;
`else
   localparam int RND     = 0;
   localparam int E_FWD10 = 78;
   localparam int E_NEG   = -1013;
`endif
   localparam int E_INV = 9;

   int CT [64] = '{
      45, 45, 45, 45, 45, 45, 45, 45,
      63, 53, 36, 12,-12,-36,-53,-63,
      59, 24,-24,-59,-59,-24, 24, 59,
      53,-12,-63,-36, 36, 63, 12,-53,
      45,-45,-45, 45, 45,-45,-45, 45,
      36,-63, 12, 53,-53,-12, 63,-36,
      24,-59, 59,-24,-24, 59,-59, 24,
      12,-36, 53,-63, 63,-53, 36,-12
   };

   int checks = 0;
   int errors = 0;
   int tx [64];
   int ey [64];
   logic [127:0] got_row [8];
   logic         got_last [8];
   int lat;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic int cf(input int k, input int j, input logic inv);
      return inv ? CT[j*8+k] : CT[k*8+j];
   endfunction

   // Reference 2-D transform with floor shift after each pass.
   function automatic void model(input logic inv);
      int z [64];
      int acc;
      for (int i = 0; i < 8; i++)
         for (int k = 0; k < 8; k++) begin
            acc = RND;
            for (int j = 0; j < 8; j++) acc += tx[i*8+j] * cf(k, j, inv);
            z[i*8+k] = acc >>> 7;
         end
      for (int i = 0; i < 8; i++)
         for (int k = 0; k < 8; k++) begin
            acc = RND;
            for (int j = 0; j < 8; j++) acc += cf(k, j, inv) * z[j*8+i];
            ey[k*8+i] = acc >>> 7;
         end
   endfunction

   task automatic send_block(input logic m0, input logic mrest);
      for (int r = 0; r < 8; r++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.in_mode  = (r == 0) ? m0 : mrest;
         for (int j = 0; j < 8; j++) bus.in_row[j*8 +: 8] = tx[r*8+j][7:0];
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_mode  = 1'b0;
   endtask

   task automatic wait_out(input string tag);
      int rdy_seen = 0;
      lat = 0;
      forever begin
         @(negedge clk);
         if (bus.out_valid || lat >= 400) break;
         if (bus.in_ready || !busy) rdy_seen++;
         @(posedge clk);
         lat++;
      end
      chk({tag, "_latency"}, lat, 129);
      chk({tag, "_inready_low"}, rdy_seen, 0);
   endtask

   task automatic recv_block(input string tag, input logic bp);
      int beat = 0, cyc = 0, sc = 0, unstable = 0;
      logic stalled = 1'b0;
      logic [127:0] hr = '0;
      logic hl = 1'b0;
      while (beat < 8 && cyc < 200) begin
         if (bus.out_valid) begin
            if (stalled && (bus.out_row !== hr || bus.out_last !== hl)) unstable++;
            bus.out_ready = !bp || (sc == 2);
            if (bus.out_ready) begin
               got_row[beat]  = bus.out_row;
               got_last[beat] = bus.out_last;
               beat++;
               sc = 0;
               stalled = 1'b0;
            end else begin
               sc++;
               stalled = 1'b1;
               hr = bus.out_row;
               hl = bus.out_last;
            end
         end else begin
            bus.out_ready = 1'b0;
         end
         @(posedge clk);
         @(negedge clk);
         cyc++;
      end
      bus.out_ready = 1'b0;
      chk({tag, "_beats"}, beat, 8);
      chk({tag, "_stable"}, unstable, 0);
      chk({tag, "_done_pulse"}, done, 1);
      chk({tag, "_inready_back"}, bus.in_ready, 1);
      @(negedge clk);
      chk({tag, "_done_once"}, done, 0);
   endtask

   task automatic check_rows(input string tag);
      logic [127:0] er;
      for (int b = 0; b < 8; b++) begin
         for (int j = 0; j < 8; j++) er[j*16 +: 16] = 16'(ey[b*8+j]);
         chk($sformatf("%s_row%0d", tag, b), got_row[b], er);
         chk($sformatf("%s_last%0d", tag, b), got_last[b], (b == 7));
      end
   endtask

   task automatic fill_const(input int v);
      for (int i = 0; i < 64; i++) tx[i] = v;
   endtask

   task automatic expect_dc(input int v);
      for (int i = 0; i < 64; i++) ey[i] = 0;
      ey[0] = v;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_row    = '0;
      bus.in_mode   = 1'b0;
      bus.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_row", bus.out_row, 0);
      chk("rst_out_last", bus.out_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      reset = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", bus.in_ready, 1);

      // Forward, constant 10: only the DC term survives.
      fill_const(10);
      expect_dc(E_FWD10);
      send_block(1'b0, 1'b0);
      wait_out("fwd10");
      recv_block("fwd10", 1'b0);
      check_rows("fwd10");

      // Inverse of a lone DC of 78 spreads evenly to 9 everywhere.
      fill_const(0);
      tx[0] = 78;
      for (int i = 0; i < 64; i++) ey[i] = E_INV;
      send_block(1'b1, 1'b1);
      wait_out("inv");
      recv_block("inv", 1'b0);
      check_rows("inv");

      // Random forward block under 0,0,1 backpressure.
      for (int i = 0; i < 64; i++) tx[i] = int'($urandom_range(255, 0)) - 128;
      model(1'b0);
      send_block(1'b0, 1'b0);
      wait_out("rndf");
      recv_block("rndf", 1'b1);
      check_rows("rndf");

      // Random inverse block.
      for (int i = 0; i < 64; i++) tx[i] = int'($urandom_range(255, 0)) - 128;
      model(1'b1);
      send_block(1'b1, 1'b1);
      wait_out("rndi");
      recv_block("rndi", 1'b0);
      check_rows("rndi");

      // Reset pulse while the second pass runs abandons the block.
      fill_const(10);
      send_block(1'b0, 1'b0);
      repeat (100) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("midrst_out_valid", bus.out_valid, 0);
      chk("midrst_in_ready", bus.in_ready, 1);
      chk("midrst_busy", busy, 0);
      @(negedge clk);
      reset = 1'b1;

      fill_const(10);
      expect_dc(E_FWD10);
      send_block(1'b0, 1'b0);
      wait_out("fresh");
      recv_block("fresh", 1'b0);
      check_rows("fresh");

      // Mode is taken from row 0 only.
      fill_const(10);
      expect_dc(E_FWD10);
      send_block(1'b0, 1'b1);
      wait_out("modes");
      recv_block("modes", 1'b0);
      check_rows("modes");

      // Most negative input everywhere: Z=-360, Y00=floor(-129600/128).
      fill_const(-128);
      expect_dc(E_NEG);
      send_block(1'b0, 1'b0);
      wait_out("neg");
      recv_block("neg", 1'b0);
      check_rows("neg");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
